// File: rtl/booth_seq_multiplier.sv
// Sequential radix-4 Booth multiplier for floating-point significands.
// Retires one Booth digit per clock; the result is held until the consumer takes it.
module booth_seq_multiplier #(
    parameter int MANT_W = 23,
    parameter int HIDDEN = 1
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [MANT_W-1:0]               a_frac,
    input  logic [MANT_W-1:0]               b_frac,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [2*(MANT_W+HIDDEN)-1:0]    product,
    output logic                            norm_hi
);
    localparam int N      = MANT_W + HIDDEN;
    localparam int NDIG   = N / 2 + 1;
    localparam int ACC_W  = 2 * N + 2;
    localparam int MULT_W = 2 * NDIG + 1;
    localparam int CNT_W  = $clog2(NDIG) + 1;

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [N-1:0]        w_a_sig;
    logic [N-1:0]        w_b_sig;
    logic [ACC_W-1:0]    r_mcand;
    logic [MULT_W-1:0]   r_mult;
    logic [ACC_W-1:0]    r_acc;
    logic [CNT_W-1:0]    r_cnt;
    logic [2*N-1:0]      r_prod;
    logic [ACC_W-1:0]    w_pp;
    logic [ACC_W-1:0]    w_acc_next;
    logic                w_accept;
    logic                w_last;

    generate
        if (HIDDEN != 0) begin : g_hidden
            assign w_a_sig = {1'b1, a_frac};
            assign w_b_sig = {1'b1, b_frac};
        end else begin : g_plain
            assign w_a_sig = a_frac;
            assign w_b_sig = b_frac;
        end
    endgenerate

    assign w_accept = in_valid && (r_state == S_IDLE);
    assign w_last   = (r_state == S_BUSY) && (r_cnt == CNT_W'(NDIG - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (in_valid)  w_state_next = S_BUSY;
            S_BUSY:  if (w_last)    w_state_next = S_DONE;
            S_DONE:  if (out_ready) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (r_state == S_IDLE);
        out_valid = (r_state == S_DONE);
    end

    // r_mult[2:0] is always {y[2i+1], y[2i], y[2i-1]} of the digit being retired.
    always_comb begin
        case (r_mult[2:0])
            3'b001, 3'b010: w_pp = r_mcand;
            3'b011:         w_pp = r_mcand << 1;
            3'b100:         w_pp = -(r_mcand << 1);
            3'b101, 3'b110: w_pp = -r_mcand;
            default:        w_pp = '0;
        endcase
    end

    assign w_acc_next = r_acc + w_pp;

    // Multiplicand bits shifted past the top are dropped: the sum is exact modulo
    // 2^ACC_W and the true product fits, so the low 2N bits come out exact.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mcand <= '0;
            r_mult  <= '0;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_prod  <= '0;
        end else if (w_accept) begin
            r_mcand <= {{(ACC_W - N){1'b0}}, w_a_sig};
            r_mult  <= {{(MULT_W - N - 1){1'b0}}, w_b_sig, 1'b0};
            r_acc   <= '0;
            r_cnt   <= '0;
        end else if (r_state == S_BUSY) begin
            r_acc   <= w_acc_next;
            r_mcand <= r_mcand << 2;
            r_mult  <= r_mult >> 2;
            r_cnt   <= r_cnt + CNT_W'(1);
            if (w_last) begin
                r_prod <= w_acc_next[2*N-1:0];
            end
        end
    end

    assign product = r_prod;
    assign norm_hi = r_prod[2*N-1];

endmodule
